fp_mul_result_collector: RTL and testbench
==========================================

Name: fp_mul_result_collector

Overview:
- Downstream stage of the FP multiplier; consumes its serial byte-wide result stream.
- On each READY rise, deserializes the 8 result bytes (LSB first) into one IEEE-754 binary64 word.
- Buffers words in a small FIFO and presents them on a 64-bit valid/ready interface to the result checker or host logic.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2)
- NBYTES, 8, bytes per result word (binary64)

Ports:
- CLK  input  1  system clock, rising-edge active
- RESET_N  input  1  asynchronous active-low reset
- READY_IN  input  1  multiplier READY; a rising edge marks byte 0
- DATA_IN  input  8  multiplier DATA_OUT byte stream
- OUT_VALID  output  1  FIFO head word valid
- OUT_READY  input  1  consumer accepts head word
- OUT_DATA  output  64  FIFO head word, {sign, exp[62:52], frac[51:0]}
- COUNT  output  $clog2(DEPTH+1)  current FIFO occupancy
- OVERFLOW  output  1  sticky: a completed word was dropped
- CLR_OVF  input  1  synchronous clear of OVERFLOW
- OUT_CLASS  output  5  head-word class (present only with FP_CLASS_EN)

Behaviour:
- One clock domain; reset is asynchronous and active-low (RESET_N). It clears the FSM to IDLE, the byte counter, the shift register, the FIFO pointers, the READY_IN history register, OUT_VALID, COUNT, OVERFLOW and OUT_CLASS. OUT_DATA resets to 0.
- Stream timing: cycle 0 is the first cycle READY_IN is high after being low. DATA_IN carries byte k during cycle k, for k = 0..7.
- READY_IN rise is detected with a registered copy: READY_IN=1 and ready_q=0.
- FSM IDLE: on a detected rise, capture byte 0 into bits [7:0], set byte counter to 1, go to CAPTURE.
- FSM CAPTURE: each cycle, capture DATA_IN into bits [8k+7:8k] and increment the counter.
- On the byte-7 edge, the assembled word is pushed into the FIFO and the FSM returns to IDLE.
- READY_IN edges during CAPTURE are ignored. No re-arm happens until READY_IN has been seen low again.
- Latency: with the FIFO empty, OUT_VALID=1 at cycle 8 with OUT_DATA equal to the word.
- FIFO pop: on any edge where OUT_VALID && OUT_READY.
- OUT_DATA and OUT_CLASS are stable while OUT_VALID=1 and OUT_READY=0.
- Push with FIFO not full: the word is written and COUNT increments, unless a pop occurs in the same cycle, in which case COUNT is unchanged.
- Push with FIFO full and a pop in the same cycle: the word is accepted and COUNT stays at DEPTH.
- Push with FIFO full and no pop: the word is dropped, FIFO contents are unchanged, and OVERFLOW is set.
- OVERFLOW: CLR_OVF clears it next edge. If a set and CLR_OVF coincide, the set wins.
- Pop with FIFO empty: ignored; OUT_VALID=0.
- Pointers wrap modulo DEPTH. Full is COUNT==DEPTH; empty is COUNT==0.
- RESET_N asserted mid-capture discards the partial word; no push occurs.

Optional Feature:
- Macro FP_CLASS_EN.
- When defined: the class is computed at push time, stored per entry, and driven on OUT_CLASS for the head word.
  - OUT_CLASS = {nan, inf, zero, subnormal, sign}.
  - nan: exp=7FF and frac!=0. inf: exp=7FF and frac=0.
  - zero: exp=0 and frac=0. subnormal: exp=0 and frac!=0.
  - sign: bit 63.
  - Resets to 0.
- When undefined: the OUT_CLASS port and its storage are absent; all other behaviour is identical.

Decomposition:
- Shared package fp_mul_pkg holds:
  - FP64 field widths and positions: SIGN_BIT=63, EXP_MSB=62, EXP_LSB=52, FRAC_W=52, EXP_MAX=11'h7FF
  - NBYTES=8
  - class bit index constants
  - FSM state enum {IDLE, CAPTURE}
- The FIFO is a natural sub-module: fp_result_fifo, parameterised by DEPTH and width (64 or 69 with class bits). It provides the push/pop/full/empty/count and simultaneous push-pop-when-full rules.
- Deserializer FSM and overflow logic stay in the top module.

Test Plan:
- Single word, bytes 00 00 00 00 00 00 F0 3F, OUT_READY=1 -> OUT_VALID=1 at cycle 8 for one cycle, OUT_DATA=64'h3FF0000000000000, COUNT returns to 0.
- Five back-to-back words, OUT_READY=0 (A1..A5; payload 64'hA1A1A1A1A1A1A1A1 etc.) -> COUNT=4, OVERFLOW=1 after word 5. Draining yields A1..A4 in order and A5 is absent. CLR_OVF -> OVERFLOW=0.
- FIFO full, OUT_READY=1 on the same edge as the byte-7 push -> COUNT stays 4, OVERFLOW stays 0, the new word is last out.
- RESET_N low for 1 cycle after byte 3 of word X, then full word 64'hC000000000000000 -> only C000000000000000 emerges; COUNT=1 before pop.
- READY_IN held high 16 cycles -> exactly one word captured.
- FP_CLASS_EN defined, words 7FF8000000000000, 8000000000000000, FFF0000000000000, 0000000000000001 -> OUT_CLASS 10000, 00101, 01001, 00010.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared FP64 field layout, class encoding and collector FSM states
// for the FP multiplier result path.
package fp_mul_pkg;

  localparam int          SIGN_BIT = 63;
  localparam int          EXP_MSB  = 62;
  localparam int          EXP_LSB  = 52;
  localparam int          FRAC_W   = 52;
  localparam logic [10:0] EXP_MAX  = 11'h7FF;

  localparam int NBYTES = 8;

  // Class vector layout: {nan, inf, zero, subnormal, sign}
  localparam int CLS_W    = 5;
  localparam int CLS_SIGN = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_ZERO = 2;
  localparam int CLS_INF  = 3;
  localparam int CLS_NAN  = 4;

  typedef enum logic {
    IDLE,
    CAPTURE
  } state_t;

  function automatic logic [CLS_W-1:0] fp_class(input logic [63:0] w);
    logic [10:0] exp_f;
    logic        frac_nz;
    logic [CLS_W-1:0] cls;
    exp_f   = w[EXP_MSB:EXP_LSB];
    frac_nz = |w[FRAC_W-1:0];
    cls             = '0;
    cls[CLS_SIGN]   = w[SIGN_BIT];
    cls[CLS_SUB]    = (exp_f == 11'h000) &&  frac_nz;
    cls[CLS_ZERO]   = (exp_f == 11'h000) && !frac_nz;
    cls[CLS_INF]    = (exp_f == EXP_MAX) && !frac_nz;
    cls[CLS_NAN]    = (exp_f == EXP_MAX) &&  frac_nz;
    return cls;
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Small register-based FIFO with combinational head read; a push into a
// full FIFO is accepted only when a pop happens on the same edge.
module fp_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          empty;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= din;
        end
      end
    end
  endgenerate

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign valid = !empty;
  assign count = count_reg;

endmodule

// File: rtl/fp_mul_result_collector.sv
// Deserialises the multiplier's LSB-first byte stream into binary64 words
// and queues them. Define FP_CLASS_EN to add per-word class on OUT_CLASS.
module fp_mul_result_collector
  import fp_mul_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NBYTES = fp_mul_pkg::NBYTES
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       READY_IN,
  input  logic [7:0]                 DATA_IN,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [8*NBYTES-1:0]        OUT_DATA,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       OVERFLOW,
  input  logic                       CLR_OVF
`ifdef FP_CLASS_EN
  ,
  output logic [CLS_W-1:0]           OUT_CLASS
`endif
);

  localparam int WORD_W = 8 * NBYTES;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);
`ifdef FP_CLASS_EN
  localparam int ENTRY_W = WORD_W + CLS_W;
`else
  localparam int ENTRY_W = WORD_W;
`endif

  state_t                  state_reg, state_next;
  logic                    ready_q;
  logic                    rise;
  logic [CNT_W-1:0]        byte_cnt_reg;
  logic [WORD_W-9:0]       shift_reg;
  logic [NBYTES-2:0]       byte_en;
  logic                    push;
  logic                    fifo_full;
  logic                    drop;
  logic                    ovf_reg;
  logic [WORD_W-1:0]       push_word;
  logic [ENTRY_W-1:0]      fifo_din;
  logic [ENTRY_W-1:0]      fifo_dout;

  assign rise = READY_IN && !ready_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE:    if (rise) state_next = CAPTURE;
      CAPTURE: if (byte_cnt_reg == LAST) begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ready_q      <= 1'b0;
      byte_cnt_reg <= '0;
    end else begin
      ready_q <= READY_IN;
      if (state_reg == IDLE) begin
        if (rise) byte_cnt_reg <= CNT_W'(1);
      end else if (byte_cnt_reg == LAST) begin
        byte_cnt_reg <= '0;
      end else begin
        byte_cnt_reg <= byte_cnt_reg + 1'b1;
      end
    end
  end

  // The top byte is never stored: it goes straight into the FIFO with the
  // rest of the word on the final capture edge.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES - 1; gi++) begin : g_byte
      if (gi == 0) begin : g_first
        assign byte_en[gi] = (state_reg == IDLE) && rise;
      end else begin : g_rest
        assign byte_en[gi] = (state_reg == CAPTURE) && (byte_cnt_reg == CNT_W'(gi));
      end
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)         shift_reg[8*gi +: 8] <= '0;
        else if (byte_en[gi]) shift_reg[8*gi +: 8] <= DATA_IN;
      end
    end
  endgenerate

  assign push_word = {DATA_IN, shift_reg};
  assign drop      = push && fifo_full && !OUT_READY;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     ovf_reg <= 1'b0;
    else if (drop)    ovf_reg <= 1'b1;
    else if (CLR_OVF) ovf_reg <= 1'b0;
  end

`ifdef FP_CLASS_EN
  assign fifo_din  = {fp_class(push_word), push_word};
  assign OUT_CLASS = fifo_dout[ENTRY_W-1:WORD_W];
`else
  assign fifo_din  = push_word;
`endif

  fp_result_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (OUT_READY),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .valid (OUT_VALID),
    .full  (fifo_full),
    .count (COUNT)
  );

  assign OUT_DATA = fifo_dout[WORD_W-1:0];
  assign OVERFLOW = ovf_reg;

endmodule

// File: tb/tb_fp_mul_result_collector.sv
// Scoreboard bench for fp_mul_result_collector; class checks are active
// when FP_CLASS_EN is defined.
module tb_fp_mul_result_collector;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        READY_IN;
  logic [7:0]  DATA_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [63:0] OUT_DATA;
  logic [2:0]  COUNT;
  logic        OVERFLOW;
  logic        CLR_OVF;
`ifdef FP_CLASS_EN
  logic [4:0]  OUT_CLASS;
`endif

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  cls;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp_mul_result_collector #(.DEPTH(4), .NBYTES(8)) dut (
    .CLK       (clk),
    .RESET_N   (RESET_N),
    .READY_IN  (READY_IN),
    .DATA_IN   (DATA_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .CLR_OVF   (CLR_OVF)
`ifdef FP_CLASS_EN
    ,
    .OUT_CLASS (OUT_CLASS)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [63:0] w, input logic [4:0] c);
    exp_q.push_back('{data: w, cls: c});
  endtask

  // Drives bytes 0..7 on consecutive cycles; optionally pops on the byte-7 edge.
  task automatic send_word(input logic [63:0] w, input bit pop_last);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      READY_IN = 1'b1;
      DATA_IN  = w[8*k +: 8];
      if (pop_last && k == 7) OUT_READY = 1'b1;
    end
    @(negedge clk);
    READY_IN = 1'b0;
    DATA_IN  = 8'h00;
    if (pop_last) OUT_READY = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Monitor: every accepted head word is checked against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (RESET_N && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %h required none", OUT_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("pop word %h (expected %h)", OUT_DATA, e.data);
        check("out_data", OUT_DATA, e.data);
`ifdef FP_CLASS_EN
        check("out_class", 64'(OUT_CLASS), 64'(e.cls));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    RESET_N   = 1'b0;
    READY_IN  = 1'b0;
    DATA_IN   = 8'h00;
    OUT_READY = 1'b0;
    CLR_OVF   = 1'b0;
    idle(2);
    #1;
    check("rst_valid", OUT_VALID, 1'b0);
    check("rst_count", COUNT, 3'd0);
    check("rst_ovf",   OVERFLOW, 1'b0);
    check("rst_data",  OUT_DATA, 64'h0);
    @(negedge clk);
    RESET_N = 1'b1;
    idle(2);

    // Single word, consumer always ready: valid for exactly cycle 8.
    OUT_READY = 1'b1;
    expect_word(64'h3FF0000000000000, 5'b00000);
    send_word(64'h3FF0000000000000, 1'b0);
    #1;
    check("lat_valid", OUT_VALID, 1'b1);
    check("lat_data",  OUT_DATA, 64'h3FF0000000000000);
    @(negedge clk); #1;
    check("single_valid_low", OUT_VALID, 1'b0);
    check("single_count", COUNT, 3'd0);
    OUT_READY = 1'b0;
    idle(2);

    // Overflow: fifth word dropped.
    for (int i = 0; i < 5; i++) begin
      logic [63:0] w;
      w = {8{8'hA1 + 8'(i)}};
      if (i < 4) expect_word(w, 5'b00001);
      send_word(w, 1'b0);
    end
    #1;
    check("ovf_count", COUNT, 3'd4);
    check("ovf_set",   OVERFLOW, 1'b1);
    @(negedge clk);
    OUT_READY = 1'b1;
    idle(5);
    OUT_READY = 1'b0;
    #1;
    check("drain_count", COUNT, 3'd0);
    check("ovf_sticky",  OVERFLOW, 1'b1);
    @(negedge clk);
    CLR_OVF = 1'b1;
    @(negedge clk);
    CLR_OVF = 1'b0;
    #1;
    check("ovf_clear", OVERFLOW, 1'b0);

    // Full FIFO with a pop on the push edge: new word accepted, no overflow.
    for (int i = 0; i < 4; i++) begin
      logic [63:0] w;
      w = {8{8'hB1 + 8'(i)}};
      expect_word(w, 5'b00001);
      send_word(w, 1'b0);
    end
    #1;
    check("full_count", COUNT, 3'd4);
    expect_word(64'hB5B5B5B5B5B5B5B5, 5'b00001);
    send_word(64'hB5B5B5B5B5B5B5B5, 1'b1);
    #1;
    check("pushpop_count", COUNT, 3'd4);
    check("pushpop_ovf",   OVERFLOW, 1'b0);
    @(negedge clk);
    OUT_READY = 1'b1;
    idle(5);
    OUT_READY = 1'b0;
    #1;
    check("pushpop_drain", COUNT, 3'd0);

    // Reset mid-capture discards the partial word.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      READY_IN = 1'b1;
      DATA_IN  = 8'h11 + 8'(k);
    end
    @(negedge clk);
    RESET_N  = 1'b0;
    READY_IN = 1'b0;
    DATA_IN  = 8'h00;
    @(negedge clk);
    RESET_N = 1'b1;
    idle(1);
    expect_word(64'hC000000000000000, 5'b00001);
    send_word(64'hC000000000000000, 1'b0);
    #1;
    check("rst_mid_count", COUNT, 3'd1);
    check("rst_mid_head",  OUT_DATA, 64'hC000000000000000);
    @(negedge clk);
    OUT_READY = 1'b1;
    idle(3);
    OUT_READY = 1'b0;

    // READY_IN held high 16 cycles captures exactly one word.
    begin
      logic [63:0] w;
      w = 64'h0123456789ABCDEF;
      expect_word(w, 5'b00000);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        READY_IN = 1'b1;
        DATA_IN  = (k < 8) ? w[8*k +: 8] : 8'hEE;
      end
      @(negedge clk);
      READY_IN = 1'b0;
      DATA_IN  = 8'h00;
      idle(2);
      #1;
      check("hold_count", COUNT, 3'd1);
      @(negedge clk);
      OUT_READY = 1'b1;
      idle(3);
      OUT_READY = 1'b0;
      #1;
      check("hold_drain", COUNT, 3'd0);
    end

    // Special-value words (class checked when enabled).
    OUT_READY = 1'b1;
    expect_word(64'h7FF8000000000000, 5'b10000);
    send_word(64'h7FF8000000000000, 1'b0);
    expect_word(64'h8000000000000000, 5'b00101);
    send_word(64'h8000000000000000, 1'b0);
    expect_word(64'hFFF0000000000000, 5'b01001);
    send_word(64'hFFF0000000000000, 1'b0);
    expect_word(64'h0000000000000001, 5'b00010);
    send_word(64'h0000000000000001, 1'b0);
    idle(3);
    OUT_READY = 1'b0;
    idle(1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
